// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - muxes several UART TX lines onto one TXD, switching owner only at idle
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter  int NUM_CH      = 2,
  parameter  int BAUD_PERIOD = 4,
  parameter  int IDLE_BITS   = 10,
  parameter  int RESET_CH    = 0,
  localparam int CHW         = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] tx_in,
  input  logic [CHW-1:0]    sel,
  input  logic              force_sw,
  output logic              TXD,
  output logic [CHW-1:0]    active_ch,
  output logic              switching,
  output logic              switch_done
);

  localparam int THRESH = IDLE_BITS * BAUD_PERIOD;
  localparam int IW     = $clog2(THRESH + 1);
  localparam int GW     = $clog2(BAUD_PERIOD + 1);
  localparam int SELN   = 1 << CHW;
  // Bit i set when sel value i names an existing channel.
  localparam logic [SELN-1:0] SEL_OK = {SELN{1'b1}} >> (SELN - NUM_CH);

  localparam logic [1:0] ST_PASS  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  logic [1:0]     state, state_nxt;
  logic [CHW-1:0] target, target_nxt, active_nxt;
  logic [IW-1:0]  idle_cnt, idle_nxt;
  logic [GW-1:0]  guard_cnt, guard_nxt;
  logic           txd_nxt, done_nxt;
  logic           owner_bit, sel_valid, idle_ok;

  assign owner_bit = tx_in[active_ch];
  assign sel_valid = SEL_OK[sel];
  assign idle_ok   = (idle_cnt >= IW'(THRESH));
  assign switching = (state != ST_PASS);

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    active_nxt = active_ch;
    guard_nxt  = guard_cnt;
    txd_nxt    = owner_bit;
    done_nxt   = 1'b0;
    if (!owner_bit)
      idle_nxt = '0;
    else if (idle_ok)
      idle_nxt = idle_cnt;
    else
      idle_nxt = idle_cnt + 1'b1;

    case (state)
      ST_PASS: begin
        if (sel_valid && (sel != active_ch)) begin
          target_nxt = sel;
          state_nxt  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (sel_valid)
          target_nxt = sel;
        // A request back to the current owner cancels, even over force.
        if (sel_valid && (sel == active_ch)) begin
          state_nxt = ST_PASS;
        end else if (idle_ok || force_sw) begin
          active_nxt = sel_valid ? sel : target;
          idle_nxt   = '0;
          guard_nxt  = GW'(BAUD_PERIOD);
          state_nxt  = ST_GUARD;
        end
      end
      ST_GUARD: begin
        txd_nxt   = 1'b1;
        guard_nxt = guard_cnt - 1'b1;
        if (guard_cnt <= GW'(1)) begin
          state_nxt = ST_PASS;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_PASS;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_PASS;
      TXD         <= 1'b1;
      active_ch   <= CHW'(RESET_CH);
      target      <= CHW'(RESET_CH);
      idle_cnt    <= '0;
      guard_cnt   <= '0;
      switch_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      TXD         <= txd_nxt;
      active_ch   <= active_nxt;
      target      <= target_nxt;
      idle_cnt    <= idle_nxt;
      guard_cnt   <= guard_nxt;
      switch_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a timestamp-based reference model
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM_CH   = 4;
  localparam int BAUD     = 4;
  localparam int IDLE     = 10;
  localparam int THRESH   = IDLE * BAUD;
  localparam int RESET_CH = 0;
  localparam int M_PASS = 0, M_DRAIN = 1, M_GUARD = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] tx_in = 4'b0000;
  logic [1:0] sel = 2'd0;
  logic       force_sw = 1'b0;
  logic       TXD, switching, switch_done;
  logic [1:0] active_ch;

  uart_tx_arbiter #(
    .NUM_CH(NUM_CH), .BAUD_PERIOD(BAUD), .IDLE_BITS(IDLE), .RESET_CH(RESET_CH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tx_in(tx_in), .sel(sel), .force_sw(force_sw),
    .TXD(TXD), .active_ch(active_ch), .switching(switching), .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       txd;
    logic [1:0] ch;
    logic       sw;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference: owner line quiet time is measured from the last edge it was seen low
  // (or the owner changed); the guard ends at a fixed edge number.
  int m_mode, m_owner, m_target, edge_no, zero_edge, guard_last;
  bit m_txd, m_done;

  function void model_reset();
    m_mode = M_PASS; m_owner = RESET_CH; m_target = RESET_CH;
    m_txd = 1'b1; m_done = 1'b0; zero_edge = edge_no; guard_last = 0;
  endfunction

  function void model_edge(input logic [3:0] tx, input logic [1:0] s, input bit f);
    int quiet;
    bit hi;
    edge_no++;
    hi    = tx[m_owner];
    quiet = edge_no - 1 - zero_edge;
    if (quiet > THRESH) quiet = THRESH;
    if (!hi) zero_edge = edge_no;
    m_done = 1'b0;
    m_txd  = hi;
    if (m_mode == M_GUARD) begin
      m_txd = 1'b1;
      if (edge_no == guard_last) begin
        m_mode = M_PASS; m_done = 1'b1;
      end
    end else if (int'(s) == m_owner) begin
      m_mode = M_PASS;
    end else begin
      m_target = s;
      if (m_mode == M_PASS) m_mode = M_DRAIN;
      else if (quiet >= THRESH || f) begin
        m_owner = m_target; zero_edge = edge_no;
        guard_last = edge_no + BAUD; m_mode = M_GUARD;
      end
    end
  endfunction

  function exp_t model_out();
    exp_t e;
    e.txd = m_txd; e.ch = 2'(m_owner); e.sw = (m_mode != M_PASS); e.done = m_done;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] tx, input logic [1:0] s, input bit f);
    @(negedge clk);
    reset_n = 1'b1; tx_in = tx; sel = s; force_sw = f;
    model_edge(tx, s, f);
    exp_q.push_back(model_out());
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("rst_txd", TXD, 1);
    check("rst_ch", active_ch, RESET_CH);
    check("rst_switching", switching, 0);
    check("rst_done", switch_done, 0);
    exp_q.push_back(model_out());
    repeat (n - 1) begin
      @(negedge clk);
      exp_q.push_back(model_out());
    end
  endtask

  function automatic logic [3:0] rand_with(input int ch, input bit v);
    logic [3:0] r;
    r = 4'($urandom);
    r[ch] = v;
    return r;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("txd", TXD, e.txd);
        check("active_ch", active_ch, e.ch);
        check("switching", switching, e.sw);
        check("switch_done", switch_done, e.done);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [3:0] t;
    logic [1:0] cur_sel;
    bit         busy;
    edge_no = 0;
    model_reset();
    do_reset(3);

    for (int i = 0; i < 40; i++) drive(rand_with(0, i[0]), 2'd0, 1'b0);

    for (int i = 0; i < 45; i++) drive(rand_with(0, 1'b1), 2'd0, 1'b0);
    t = rand_with(2, 1'b0); t[0] = 1'b1;
    drive(t, 2'd2, 1'b0);
    drive(t, 2'd2, 1'b0);
    check("drain_switching", switching, 1);
    check("drain_ch", active_ch, 0);
    drive(t, 2'd2, 1'b0);
    check("guard_ch", active_ch, 2);
    for (int i = 0; i < BAUD; i++) begin
      drive(t, 2'd2, 1'b0);
      check("guard_txd", TXD, 1);
    end
    check("idle_switch_done", switch_done, 1);
    for (int i = 0; i < 12; i++) drive(4'($urandom), 2'd2, 1'b0);

    for (int i = 0; i < 90; i++) drive(rand_with(2, (i % 30) != 0), 2'd1, 1'b0);
    check("midframe_wait_sw", switching, 1);
    check("midframe_wait_ch", active_ch, 2);
    for (int i = 0; i < 60; i++) drive(rand_with(2, 1'b1), 2'd1, 1'b0);
    check("midframe_switched", active_ch, 1);

    drive(rand_with(1, 1'b0), 2'd3, 1'b0);
    drive(rand_with(1, 1'b0), 2'd3, 1'b1);
    drive(rand_with(1, 1'b0), 2'd3, 1'b0);
    check("force_guard_ch", active_ch, 3);
    check("force_guard_sw", switching, 1);
    for (int i = 0; i < 8; i++) drive(rand_with(3, 1'b0), 2'd3, 1'b0);

    drive(rand_with(3, 1'b0), 2'd0, 1'b0);
    drive(rand_with(3, 1'b0), 2'd3, 1'b0);
    for (int i = 0; i < 5; i++) drive(rand_with(3, 1'b0), 2'd3, 1'b0);
    check("cancel_ch", active_ch, 3);
    check("cancel_sw", switching, 0);

    drive(rand_with(3, 1'b0), 2'd1, 1'b0);
    drive(rand_with(3, 1'b0), 2'd3, 1'b1);
    drive(rand_with(3, 1'b0), 2'd3, 1'b0);
    check("cancel_over_force_ch", active_ch, 3);
    check("cancel_over_force_sw", switching, 0);

    drive(rand_with(3, 1'b0), 2'd2, 1'b0);
    drive(rand_with(3, 1'b0), 2'd2, 1'b1);
    drive(rand_with(2, 1'b0), 2'd2, 1'b0);
    do_reset(2);
    for (int i = 0; i < 10; i++) drive(4'($urandom), 2'd0, 1'b0);

    cur_sel = 2'd0;
    busy = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) busy = !busy;
      if ($urandom_range(0, 19) == 0) cur_sel = 2'($urandom);
      if ($urandom_range(0, 399) == 0)
        do_reset(1 + int'($urandom_range(0, 2)));
      else
        drive(busy ? 4'($urandom) : 4'hF, cur_sel, $urandom_range(0, 15) == 0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of UART TX sources, legal range 2..8.
REQ-002 SHALL have parameter BAUD_PERIOD, default 4: clk cycles per UART bit, minimum 1.
REQ-003 SHALL have parameter IDLE_BITS, default 10: bit times of continuous mark required before a switch; THRESH = IDLE_BITS*BAUD_PERIOD.
REQ-004 SHALL have parameter RESET_CH, default 0: channel that owns TXD after reset.
REQ-005 SHALL define local CHW = clog2(NUM_CH), minimum 1.
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 tx_in  input  NUM_CH  serial TX line of each source, idle high.
REQ-009 sel  input  CHW  requested owner; values >= NUM_CH are ignored.
REQ-010 force  input  1  in DRAIN, skips the idle wait.
REQ-011 TXD  output  1  registered muxed serial output.
REQ-012 active_ch  output  CHW  current owner.
REQ-013 switching  output  1  high while state is DRAIN or GUARD.
REQ-014 switch_done  output  1  one-cycle pulse when a switch completes.

Function
REQ-015 SHALL implement a state machine with states PASS, DRAIN and GUARD.
REQ-016 SHALL keep idle_cnt, which counts consecutive cycles of tx_in[active_ch]==1, saturates at THRESH, and clears to 0 in any cycle where tx_in[active_ch]==0.
REQ-017 In PASS and DRAIN, TXD SHALL equal tx_in[active_ch] delayed by exactly 1 cycle.
REQ-018 In PASS, a valid sel != active_ch SHALL move the state to DRAIN on the next edge; active_ch SHALL be unchanged.
REQ-019 In DRAIN, if sel == active_ch, the state SHALL return to PASS; this is a cancel, and switch_done SHALL NOT pulse.
REQ-020 In DRAIN, if sel is invalid, the state SHALL stay in DRAIN and the last valid target is kept; the target register SHALL be updated on every valid sel.
REQ-021 In DRAIN, if (idle_cnt >= THRESH or force) and no cancel: active_ch SHALL take the target, idle_cnt SHALL clear to 0, and the state SHALL move to GUARD.
REQ-022 Cancel SHALL take priority over force when both occur in the same cycle.
REQ-023 In GUARD, TXD SHALL be driven 1 for exactly BAUD_PERIOD cycles.
REQ-024 After GUARD, the state SHALL move to PASS, and switch_done SHALL be 1 for one cycle on the first PASS cycle.
REQ-025 In GUARD, sel changes SHALL be ignored until PASS is reached.
REQ-026 idle_cnt SHALL keep counting the new owner during GUARD.
REQ-027 The guard counter SHALL be clog2(BAUD_PERIOD+1) bits wide and SHALL be loaded on entry to GUARD.
REQ-028 The tx_in inputs are synchronous to clk; no synchronizers SHALL be inserted.

Reset
REQ-029 While reset_n=0, the block SHALL asynchronously set: TXD=1, active_ch=RESET_CH, state=PASS, idle_cnt=0, target=RESET_CH, guard counter=0, switching=0, switch_done=0.
REQ-030 A reset asserted in DRAIN or GUARD SHALL abort the switch, with no switch_done pulse.
REQ-031 After reset release, the first TXD update SHALL occur on the first posedge clk.

Verification
NUM_CH=4, BAUD_PERIOD=4, IDLE_BITS=10, so THRESH=40.
REQ-032 Reset: hold reset_n=0 with tx_in=4'b0000 -> TXD=1, active_ch=0, switching=0, switch_done=0.
REQ-033 Passthrough: toggle tx_in[0] each cycle with tx_in[1..3] random -> TXD equals tx_in[0] 1 cycle later; other channels have no effect.
REQ-034 Idle switch: tx_in[0] high for more than 40 cycles, then sel=2 at cycle T ->
- DRAIN at T+1;
- GUARD at T+2 with active_ch=2;
- TXD=1 for cycles T+3..T+6;
- switch_done=1 on the first PASS cycle;
- TXD then follows tx_in[2].
REQ-035 Mid-frame wait: tx_in[0] pulses low every 30 cycles and sel=1 -> switching stays 1 with no switch; then hold tx_in[0] high -> switch occurs after 40 consecutive high cycles.
REQ-036 Force and cancel:
- force=1 in DRAIN with tx_in[0]=0 -> GUARD on the next edge.
- A separate run with sel returned to 0 during DRAIN -> PASS, active_ch=0, no switch_done.
- force and cancel asserted in the same cycle -> cancel wins.
REQ-037 Reset mid-GUARD: assert reset_n=0 in the second GUARD cycle -> TXD=1 and active_ch=RESET_CH immediately; no switch_done after release.
